dds_phase_accumulator: RTL and testbench

Phase generator of the DDS core. It accumulates a frequency tuning word (FTW) every enabled clock and emits the truncated, offset-adjusted phase that addresses the waveform ROMs (sine, square, triangle). FTW changes are handshaked and applied only at accumulator wrap-around, so frequency changes are phase-continuous and glitch-free. It also emits a wrap strobe for scope triggering and period measurement.

---
 rtl/dds_phase_accumulator_pkg.sv | 28 ++
 rtl/dds_phase_accumulator_lfsr16.sv | 36 +++
 rtl/dds_phase_accumulator.sv | 159 +++++++++++++++
 tb/tb_dds_phase_accumulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_phase_accumulator_pkg.sv
// Shared definitions for the DDS phase accumulator: ROM phase width macros,
// default accumulator width, FSM encodings and LFSR constants.
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif
`ifndef ROM_PHASE_MAX_VAL
`define ROM_PHASE_MAX_VAL ((1 << `ROM_PHASE_BIT) - 1)
`endif

package dds_phase_accumulator_pkg;

  localparam int DDS_ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } dds_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dds_phase_accumulator_lfsr16.sv
// 16-bit maximal-length Galois LFSR used to dither phase truncation.
// Only instantiated when DDS_PHASE_DITHER_EN is defined.
module dds_lfsr16
  import dds_phase_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] out
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next-state: advance once per enabled cycle
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = lfsr16_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State register, reset to the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_q;

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator with wrap-synchronised FTW updates and phase offset.
// Define DDS_PHASE_DITHER_EN to add LFSR dither ahead of phase truncation.
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

module dds_phase_accumulator
  import dds_phase_accumulator_pkg::*;
#(
  parameter int               ACC_W     = DDS_ACC_W,
  parameter int               PHASE_W   = `ROM_PHASE_BIT,
  parameter logic [ACC_W-1:0] FTW_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] poff_in,
  input  logic               poff_valid,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap
);

  dds_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_active_q, ftw_active_d;
  logic [ACC_W-1:0]   ftw_pending_q, ftw_pending_d;
  logic [PHASE_W-1:0] poff_q, poff_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               carry_q, carry_d;
  logic               wrap_q, wrap_d;
  logic               ftw_ready_q, ftw_ready_d;

  logic [ACC_W:0]     sum_s;
  logic               carry_s;
  logic               hs_s;
  logic [ACC_W-1:0]   trunc_src_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, ftw_active_q};
  assign carry_s = sum_s[ACC_W];
  assign hs_s    = ftw_valid & ftw_ready_q;

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_W - PHASE_W) < 16) ? (ACC_W - PHASE_W) : 16;
  logic [15:0] lfsr_s;

  dds_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .out (lfsr_s)
  );

  // Dither lands in the fractional bits and may carry into the phase bits
  assign trunc_src_s = acc_q + {{(ACC_W-DITH_W){1'b0}}, lfsr_s[DITH_W-1:0]};
`else
  assign trunc_src_s = acc_q;
`endif

  // Datapath and FTW handshake FSM next-state logic
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    ftw_active_d  = ftw_active_q;
    ftw_pending_d = ftw_pending_q;
    poff_d        = poff_q;
    phase_d       = phase_q;
    carry_d       = carry_q;
    phase_valid_d = en;
    // wrap marks the first phase taken from the post-carry accumulator
    wrap_d        = en & carry_q;

    if (en) begin
      acc_d   = sum_s[ACC_W-1:0];
      phase_d = trunc_src_s[ACC_W-1 -: PHASE_W] + poff_q;
      carry_d = carry_s;
    end else begin
      acc_d   = acc_q;
      phase_d = phase_q;
      carry_d = carry_q;
    end

    if (poff_valid) begin
      poff_d = poff_in;
    end else begin
      poff_d = poff_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          ftw_active_d = ftw_in;
          state_d      = (ftw_in != '0) ? ST_RUN : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          ftw_pending_d = ftw_in;
          state_d       = ST_PEND;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PEND: begin
        // The carrying add itself still uses the old FTW
        if (en && carry_s) begin
          ftw_active_d = ftw_pending_q;
          state_d      = (ftw_pending_q != '0) ? ST_RUN : ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ftw_ready_d = (state_d != ST_PEND);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= (FTW_RESET != '0) ? ST_RUN : ST_IDLE;
      acc_q         <= '0;
      ftw_active_q  <= FTW_RESET;
      ftw_pending_q <= '0;
      poff_q        <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      carry_q       <= 1'b0;
      wrap_q        <= 1'b0;
      ftw_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ftw_active_q  <= ftw_active_d;
      ftw_pending_q <= ftw_pending_d;
      poff_q        <= poff_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      carry_q       <= carry_d;
      wrap_q        <= wrap_d;
      ftw_ready_q   <= ftw_ready_d;
    end
  end

  assign ftw_ready   = ftw_ready_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator with ACC_W=8, PHASE_W=4.
// With DDS_PHASE_DITHER_EN defined, only the dither checks run.
`timescale 1ns/1ps
module tb_dds_phase_accumulator;

  localparam int ACC_W   = 8;
  localparam int PHASE_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [ACC_W-1:0]   ftw_in = '0;
  logic               ftw_valid = 1'b0;
  logic               ftw_ready;
  logic [PHASE_W-1:0] poff_in = '0;
  logic               poff_valid = 1'b0;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_phase_accumulator #(
    .ACC_W     (ACC_W),
    .PHASE_W   (PHASE_W),
    .FTW_RESET (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ftw_in      (ftw_in),
    .ftw_valid   (ftw_valid),
    .ftw_ready   (ftw_ready),
    .poff_in     (poff_in),
    .poff_valid  (poff_valid),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ph, input logic pv,
                            input logic wr, input logic rdy);
    check_eq({tag, ".phase"}, 32'(phase), 32'(ph));
    check_eq({tag, ".valid"}, 32'(phase_valid), 32'(pv));
    check_eq({tag, ".wrap"}, 32'(wrap), 32'(wr));
    check_eq({tag, ".ready"}, 32'(ftw_ready), 32'(rdy));
  endtask

  task automatic handshake(input logic [7:0] f);
    ftw_in    = f;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
  endtask

`ifdef DDS_PHASE_DITHER_EN
  logic        lf_rst = 1'b1;
  logic [15:0] lf_out;

  dds_lfsr16 u_lfsr_ref (
    .clk (clk),
    .rst (lf_rst),
    .en  (1'b1),
    .out (lf_out)
  );
`endif

  // Expected phase sequences for the directed segments
  logic [3:0] run1_ph [6]  = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0, 4'h4};
  logic       run1_wr [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] poff_ph [8]  = '{4'h8, 4'hF, 4'h3, 4'h7, 4'hB, 4'hC, 4'h0, 4'h4};
  logic       poff_wr [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] stop_ph [7]  = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0, 4'h0, 4'h0};
  logic       stop_wr [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       stop_rd [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    tick();
    tick();
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

`ifdef DDS_PHASE_DITHER_EN
    begin
      int wraps = 0;
      int diffs = 0;
      int period = 0;
      handshake(8'h01);
      en = 1'b1;
      for (int t = 1; t <= 4097; t++) begin
        tick();
        if (wrap) wraps++;
        if (phase != 4'(((t - 1) % 256) >> 4)) diffs++;
      end
      check_eq("dither_wraps", 32'(wraps), 32'd16);
      check_eq("dither_hist_differs", 32'(diffs != 0), 32'd1);
      check_eq("lfsr_reset_seed", 32'(lf_out), 32'h0000ACE1);
      lf_rst = 1'b0;
      for (int i = 1; i <= 70000; i++) begin
        tick();
        if (lf_out == 16'hACE1) begin
          period = i;
          break;
        end
      end
      check_eq("lfsr_period", 32'(period), 32'd65535);
    end
`else
    // Load FTW=0x40 while disabled, then run
    handshake(8'h40);
    expect_out("load40", 4'h0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_out($sformatf("run40_%0d", i), run1_ph[i], 1'b1, run1_wr[i], 1'b1);
    end

    // Offset 3 applied from the next update, then removed
    for (int i = 0; i < 8; i++) begin
      poff_valid = (i == 0) || (i == 4);
      poff_in    = (i == 0) ? 4'h3 : 4'h0;
      tick();
      poff_valid = 1'b0;
      expect_out($sformatf("poff_%0d", i), poff_ph[i], 1'b1, poff_wr[i], 1'b1);
    end

    // FTW 0x40 -> 0x20 mid-period
    handshake(8'h20);
    expect_out("pend20_a", 4'h8, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("pend20_b", 4'hC, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("pend20_c", 4'h0, 1'b1, 1'b1, 1'b1);
    tick();
    expect_out("pend20_d", 4'h2, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("pend20_e", 4'h4, 1'b1, 1'b0, 1'b1);

    // FTW 0x40 pending, en low for 5 cycles; ftw_valid while not ready is ignored
    handshake(8'h40);
    expect_out("pend40", 4'h6, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ftw_valid = (i < 3);
      ftw_in    = 8'h08;
      tick();
      expect_out($sformatf("hold_%0d", i), 4'h6, 1'b0, 1'b0, 1'b0);
    end
    ftw_valid = 1'b0;
    en = 1'b1;
    tick();
    expect_out("resume_a", 4'h8, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("resume_b", 4'hA, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("resume_c", 4'hC, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("resume_d", 4'hE, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("resume_e", 4'h0, 1'b1, 1'b1, 1'b1);
    tick();
    expect_out("resume_f", 4'h4, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("resume_g", 4'h8, 1'b1, 1'b0, 1'b1);

    // FTW=0 handshaked in the wrap cycle: applied at the following wrap
    handshake(8'h00);
    expect_out("stop_hs", 4'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_out($sformatf("stop_%0d", i), stop_ph[i], 1'b1, stop_wr[i], stop_rd[i]);
    end

    // Restart, then reset while a FTW is pending
    handshake(8'h40);
    tick();
    handshake(8'h10);
    expect_out("rpend_a", 4'h4, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rpend_b", 4'h8, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("rst_mid", 4'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    expect_out("post_rst_a", 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    expect_out("post_rst_b", 4'h0, 1'b1, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
